pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register. It is the generic successor to the fixed-width fetch/decode latch and sits between any two adjacent stages of the ARM pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit payload under a valid/ready handshake and adds a one-entry skid buffer so that the upstream ready is a register output. It also provides a flush that squashes in-flight contents to a NOP payload, and a saturating back-pressure counter for performance debug.

---
 rtl/pipe_stage_reg_pkg.sv | 28 ++
 rtl/pipe_stage_reg_if.sv | 34 +++
 rtl/pipe_stage_reg_sat_counter.sv | 29 ++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared pipeline definitions used by every stage boundary register:
//   - NOP encodings (ARM "MOV r0,r0" instruction word and the all-zero payload)
//   - default payload widths per stage boundary
//   - the stage-state enum (EMPTY / FULL / SKID), encoded as {skid_v, main_v}
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  // ARM NOP (MOV r0, r0). Stages that want an architectural NOP in the
  // instruction field can build their NOP_VALUE from this.
  localparam logic [31:0] ARM_NOP_INSTR = 32'hE1A0_0000;

  // Default payload: instruction (32) + PC+4 (32) + addressing-mode bits (2).
  localparam int PAYLOAD_W_DEFAULT = 66;
  localparam int IF_ID_W  = PAYLOAD_W_DEFAULT;
  localparam int ID_EX_W  = PAYLOAD_W_DEFAULT;
  localparam int EX_MEM_W = PAYLOAD_W_DEFAULT;
  localparam int MEM_WB_W = PAYLOAD_W_DEFAULT;

  // Bit 0 is main_v, bit 1 is skid_v. 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Handshake bundle around one pipeline stage register.
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side
// Handshake: a word moves on a cycle where valid && ready are both high at the
// rising clock edge. The sender holds valid and data stable until that edge;
// valid never depends on ready. in_ready and out_* are register outputs.
// Modports:
//   slave  : the stage register itself
//   master : the surrounding pipeline (drives upstream offer + downstream ready)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W_DEFAULT
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that sticks at all-ones, with synchronous clear.
// Ports:
//   clk     : clock
//   i_clr   : synchronous clear (wins over increment)
//   i_inc   : increment this cycle
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic pipeline stage register with a one-entry skid buffer, flush to a NOP
// payload and a saturating back-pressure counter.
// Ports:
//   clk          : clock, all state on posedge
//   reset        : synchronous, active-high
//   flush        : squash everything this cycle (priority over handshakes)
//   bus          : pipe_stage_reg_if.slave (in_* upstream, out_* downstream)
//   stall_cycles : cycles seen with out_valid && !out_ready (saturating)
//   dbg_state    : current stage state (EMPTY / FULL / SKID)
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = PAYLOAD_W_DEFAULT,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_reg_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cycles,
  output stage_state_e       dbg_state
);

  stage_state_e      r_state;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;
  logic              r_in_ready;

  stage_state_e      w_next_state;
  logic [DATA_W-1:0] w_next_main_d;
  logic [DATA_W-1:0] w_next_skid_d;
  logic              w_accept;
  logic              w_stall;

  assign w_accept = bus.in_valid && r_in_ready;
  // main_v is bit 0 of the state encoding.
  assign w_stall  = r_state[0] && !bus.out_ready;

  // Next-state and datapath selection.
  always_comb begin
    w_next_state  = r_state;
    w_next_main_d = r_main_d;
    w_next_skid_d = r_skid_d;

    if (flush) begin
      w_next_state  = ST_EMPTY;
      w_next_main_d = NOP_VALUE;
      w_next_skid_d = NOP_VALUE;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state  = ST_FULL;
            w_next_main_d = bus.in_data;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            if (w_accept) begin
              w_next_main_d = bus.in_data;
            end else begin
              // Output drained with nothing behind it: go back to NOP.
              w_next_state  = ST_EMPTY;
              w_next_main_d = NOP_VALUE;
            end
          end else if (w_accept) begin
            // Downstream stalled while upstream still had in_ready=1:
            // park the extra word in the skid slot.
            w_next_state  = ST_SKID;
            w_next_skid_d = bus.in_data;
          end
        end
        ST_SKID: begin
          if (bus.out_ready) begin
            w_next_state  = ST_FULL;
            w_next_main_d = r_skid_d;
            w_next_skid_d = NOP_VALUE;
          end
        end
        default: begin
          w_next_state  = ST_EMPTY;
          w_next_main_d = NOP_VALUE;
          w_next_skid_d = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main_d   <= NOP_VALUE;
      r_skid_d   <= NOP_VALUE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_main_d   <= w_next_main_d;
      r_skid_d   <= w_next_skid_d;
      // Registered ready: low exactly when the skid slot will be occupied.
      r_in_ready <= !w_next_state[1];
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr   (reset),
    .i_inc   (w_stall),
    .o_count (stall_cycles)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_state[0];
  assign bus.out_data  = r_main_d;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = 66;
  localparam int CW = 4;
  localparam logic [DW-1:0] NOP = '0;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [CW-1:0] stall_cycles;
  stage_state_e  dbg_state;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW)) bus ();

  pipe_stage_reg #(
    .DATA_W    (DW),
    .NOP_VALUE (NOP),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  // The stage behaves as a FIFO of depth 2 whose ready is registered as
  // "fewer than two words held". exp_q holds the words currently inside it.
  logic [DW-1:0] exp_q[$];
  logic          m_rdy;
  int            m_cnt;
  int            n_checks;
  int            n_fail;

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model across the edge, then
  // return 1 time unit after the edge so outputs can be sampled.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic rst);
    logic acc, cons, stl;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rst;
    acc  = v && m_rdy;
    cons = (exp_q.size() > 0) && ordy;
    stl  = (exp_q.size() > 0) && !ordy;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_rdy = 1'b1;
      m_cnt = 0;
    end else begin
      if (stl && m_cnt < CNT_MAX) m_cnt++;
      if (fl) begin
        exp_q.delete();
        m_rdy = 1'b1;
      end else begin
        if (cons) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(d);
        m_rdy = (exp_q.size() < 2);
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== NOP) begin n_fail++; $display("FAIL reset_out_data got %h exp %h", bus.out_data, NOP); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    n_checks++; if (dbg_state !== ST_EMPTY) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_EMPTY); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i)) begin
        n_fail++; $display("FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, DW'(i)); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, bus.in_ready); end
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
      n_fail++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=%h", bus.out_valid, bus.out_data, NOP); end
  endtask

  task automatic test_stall_skid();
    cycle(1'b1, DW'('hA), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'('hB), 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_in_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.out_data !== DW'('hA)) begin n_fail++; $display("FAIL skid_hold got %h exp a", bus.out_data); end
    n_checks++; if (stall_cycles !== 4'd3) begin n_fail++; $display("FAIL skid_stall got %0d exp 3", stall_cycles); end
    n_checks++; if (dbg_state !== ST_SKID) begin n_fail++; $display("FAIL skid_state got %0d exp %0d", dbg_state, ST_SKID); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'('hB)) begin
      n_fail++; $display("FAIL skid_release got v=%b d=%h exp v=1 d=b", bus.out_valid, bus.out_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_ready_back got %b exp 1", bus.in_ready); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_no_dup got v=%b d=%h exp v=0", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_flush();
    cycle(1'b1, DW'('hA), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, DW'('hB), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('hC), 1'b0, 1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
      n_fail++; $display("FAIL flush_out got v=%b d=%h exp v=0 d=%h", bus.out_valid, bus.out_data, NOP); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (stall_cycles !== 4'd5) begin n_fail++; $display("FAIL flush_stall_kept got %0d exp 5", stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
        n_fail++; $display("FAIL flush_squashed[%0d] got v=%b d=%h exp v=0", i, bus.out_valid, bus.out_data); end
    end
  endtask

  task automatic test_saturation();
    cycle(1'b1, DW'('hD), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (stall_cycles !== 4'd15) begin n_fail++; $display("FAIL sat_stall got %0d exp 15", stall_cycles); end
    n_checks++; if (bus.out_data !== DW'('hD) || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold got v=%b d=%h exp v=1 d=d", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_reset_full();
    cycle(1'b1, DW'('hE), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, DW'('hF), 1'b1, 1'b0, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== NOP) begin
      n_fail++; $display("FAIL rstfull_out got v=%b d=%h exp v=0 d=%h", bus.out_valid, bus.out_data, NOP); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_in_ready got %b exp 1", bus.in_ready); end
    n_checks++; if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL rstfull_stall got %0d exp 0", stall_cycles); end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_dropped got v=%b d=%h exp v=0", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d, exp_d;
    logic v, ordy, fl, rst;
    stage_state_e exp_st;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      d    = {$urandom, $urandom, 2'($urandom)};
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 79) == 0);
      cycle(v, d, ordy, fl, rst);
      exp_d  = (exp_q.size() > 0) ? exp_q[0] : NOP;
      exp_st = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_FULL : ST_SKID;
      n_checks++; if (bus.out_valid !== (exp_q.size() > 0)) begin
        n_fail++; $display("FAIL rand_out_valid[%0d] got %b exp %b", i, bus.out_valid, exp_q.size() > 0); end
      n_checks++; if (bus.out_data !== exp_d) begin
        n_fail++; $display("FAIL rand_out_data[%0d] got %h exp %h", i, bus.out_data, exp_d); end
      n_checks++; if (bus.in_ready !== m_rdy) begin
        n_fail++; $display("FAIL rand_in_ready[%0d] got %b exp %b", i, bus.in_ready, m_rdy); end
      n_checks++; if (stall_cycles !== CW'(m_cnt)) begin
        n_fail++; $display("FAIL rand_stall[%0d] got %0d exp %0d", i, stall_cycles, m_cnt); end
      n_checks++; if (dbg_state !== exp_st) begin
        n_fail++; $display("FAIL rand_state[%0d] got %0d exp %0d", i, dbg_state, exp_st); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks      = 0;
    n_fail        = 0;
    m_rdy         = 1'b1;
    m_cnt         = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_saturation();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
